// File: rtl/inference_request_pkg.sv
// Shared widths, mode encodings, FSM states and the int16 saturator used by the
// inference request tensor normaliser.
package inference_request_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int ELEM_WIDTH  = 16;
    localparam int PROD_WIDTH  = 25;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_NORM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } fsm_e;

    function automatic logic signed [ELEM_WIDTH-1:0] sat16(input logic signed [PROD_WIDTH-1:0] v);
        if (v > 25'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -25'sd32768) begin
            return 16'sh8000;
        end
        return v[ELEM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/inference_request_tensor_normalizer_lane.sv
// One normalisation lane: ((pixel - mean) * scale) >>> FRAC_BITS, floored and
// saturated to int16. Purely combinational.
module tensor_normalize_lane
    import inference_request_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic        [PIXEL_WIDTH-1:0] pixel,
    input  logic        [PIXEL_WIDTH-1:0] mean,
    input  logic signed [ELEM_WIDTH-1:0]  scale,
    output logic signed [ELEM_WIDTH-1:0]  elem
);

    logic signed [PIXEL_WIDTH:0]  diff;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [PROD_WIDTH-1:0] shifted;

    always_comb begin
        diff    = $signed({1'b0, pixel}) - $signed({1'b0, mean});
        prod    = PROD_WIDTH'(diff) * PROD_WIDTH'(scale);
        shifted = prod >>> FRAC_BITS;
        elem    = sat16(shifted);
    end

endmodule

// File: rtl/inference_request_tensor_normalizer.sv
// Pixel-stream to tensor-stream stage: pass-through, or per-channel normalise
// with each input beat split into a LO and HI output beat of int16 elements.
module inference_request_tensor_normalizer
    import inference_request_pkg::*;
#(
    parameter int TDATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128,
    parameter int CHANNELS    = 3,
    parameter int FRAC_BITS   = 8
) (
    input  logic                      axis_aclk,
    input  logic                      axis_resetn,
    input  logic                      cfg_mode,
    input  logic [CHANNELS*8-1:0]     cfg_mean,
    input  logic [CHANNELS*16-1:0]    cfg_scale,
    input  logic [TDATA_WIDTH-1:0]    data_in_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]  data_in_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]    data_in_axis_tuser,
    input  logic                      data_in_axis_tvalid,
    input  logic                      data_in_axis_tlast,
    output logic                      data_in_axis_tready,
    output logic [TDATA_WIDTH-1:0]    data_out_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]  data_out_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]    data_out_axis_tuser,
    output logic                      data_out_axis_tvalid,
    output logic                      data_out_axis_tlast,
    input  logic                      data_out_axis_tready
);

    localparam int N    = TDATA_WIDTH / 8;
    localparam int H    = N / 2;
    localparam int NMOD = N % CHANNELS;

    fsm_e                     state_q, state_d;
    logic                     rdy_en_q;
    logic                     sop_q, sop_d;
    logic [1:0]               phase_q, phase_d;
    logic [TDATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [N-1:0]             hold_keep_q, hold_keep_d;
    logic [TUSER_WIDTH-1:0]   hold_user_q, hold_user_d;
    logic                     hold_last_q, hold_last_d;
    logic [1:0]               hold_phase_q, hold_phase_d;
    logic                     cfg_mode_q, cfg_mode_d;
    logic [CHANNELS*8-1:0]    cfg_mean_q, cfg_mean_d;
    logic [CHANNELS*16-1:0]   cfg_scale_q, cfg_scale_d;
    logic [TDATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [N-1:0]             out_keep_q, out_keep_d;
    logic [TUSER_WIDTH-1:0]   out_user_q, out_user_d;
    logic                     out_last_q, out_last_d;
    logic                     out_valid_q, out_valid_d;

    logic upper_empty, final_half, out_free, move, in_fire, hi_sel;

    logic        [PIXEL_WIDTH-1:0] lane_pixel [H];
    logic        [PIXEL_WIDTH-1:0] lane_mean  [H];
    logic signed [ELEM_WIDTH-1:0]  lane_scale [H];
    logic signed [ELEM_WIDTH-1:0]  lane_elem  [H];

    function automatic int chan_of(input logic [1:0] p, input logic hi, input int k);
        return (int'(p) + k + (hi ? H : 0)) % CHANNELS;
    endfunction

    // A held beat is finished after its LO half when passing through or when its upper half is empty.
    always_comb begin
        hi_sel      = (state_q == HI);
        upper_empty = (hold_keep_q[N-1:H] == '0);
        final_half  = hi_sel || ((state_q == LO) && ((cfg_mode_q == MODE_PASS) || upper_empty));
        out_free    = !out_valid_q || data_out_axis_tready;
        move        = (state_q != IDLE) && out_free;
    end

    assign data_in_axis_tready = rdy_en_q && ((state_q == IDLE) || (move && final_half));
    assign in_fire             = data_in_axis_tvalid && data_in_axis_tready;

    always_comb begin
        for (int k = 0; k < H; k++) begin
            lane_pixel[k] = hi_sel ? hold_data_q[(H+k)*8 +: 8] : hold_data_q[k*8 +: 8];
            lane_mean[k]  = cfg_mean_q[chan_of(hold_phase_q, hi_sel, k)*8 +: 8];
            lane_scale[k] = $signed(cfg_scale_q[chan_of(hold_phase_q, hi_sel, k)*16 +: 16]);
        end
    end

    for (genvar g = 0; g < H; g++) begin : g_lane
        tensor_normalize_lane #(
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .pixel (lane_pixel[g]),
            .mean  (lane_mean[g]),
            .scale (lane_scale[g]),
            .elem  (lane_elem[g])
        );
    end

    // FSM, holding register, phase tracking and packet-start config latch.
    always_comb begin
        state_d      = state_q;
        sop_d        = sop_q;
        phase_d      = phase_q;
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        hold_user_d  = hold_user_q;
        hold_last_d  = hold_last_q;
        hold_phase_d = hold_phase_q;
        cfg_mode_d   = cfg_mode_q;
        cfg_mean_d   = cfg_mean_q;
        cfg_scale_d  = cfg_scale_q;
        if (move) begin
            state_d = final_half ? IDLE : HI;
        end
        if (in_fire) begin
            state_d      = LO;
            hold_data_d  = data_in_axis_tdata;
            hold_keep_d  = data_in_axis_tkeep;
            hold_user_d  = data_in_axis_tuser;
            hold_last_d  = data_in_axis_tlast;
            hold_phase_d = phase_q;
            phase_d      = data_in_axis_tlast ? 2'd0 : 2'((int'(phase_q) + NMOD) % CHANNELS);
            sop_d        = data_in_axis_tlast;
            if (sop_q) begin
                cfg_mode_d  = cfg_mode;
                cfg_mean_d  = cfg_mean;
                cfg_scale_d = cfg_scale;
            end
        end
    end

    // Output register: loaded from the selected half of the holding register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        if (out_valid_q && data_out_axis_tready) begin
            out_valid_d = 1'b0;
        end
        if (move) begin
            out_valid_d = 1'b1;
            out_user_d  = hold_user_q;
            if (cfg_mode_q == MODE_PASS) begin
                out_data_d = hold_data_q;
                out_keep_d = hold_keep_q;
                out_last_d = hold_last_q;
            end else begin
                out_user_d[15:0] = {hold_user_q[14:0], 1'b0};
                for (int k = 0; k < H; k++) begin
                    out_data_d[k*16 +: 16] = lane_elem[k];
                    out_keep_d[k*2 +: 2]   = {2{hi_sel ? hold_keep_q[H+k] : hold_keep_q[k]}};
                end
                out_last_d = hold_last_q && (hi_sel || upper_empty);
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q      <= IDLE;
            rdy_en_q     <= 1'b0;
            sop_q        <= 1'b1;
            phase_q      <= '0;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            hold_user_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_phase_q <= '0;
            cfg_mode_q   <= MODE_PASS;
            cfg_mean_q   <= '0;
            cfg_scale_q  <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            sop_q        <= sop_d;
            phase_q      <= phase_d;
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            hold_user_q  <= hold_user_d;
            hold_last_q  <= hold_last_d;
            hold_phase_q <= hold_phase_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_mean_q   <= cfg_mean_d;
            cfg_scale_q  <= cfg_scale_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_user_q   <= out_user_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign data_out_axis_tdata  = out_data_q;
    assign data_out_axis_tkeep  = out_keep_q;
    assign data_out_axis_tuser  = out_user_q;
    assign data_out_axis_tlast  = out_last_q;
    assign data_out_axis_tvalid = out_valid_q;

endmodule
